stream_data_gen: RTL and testbench

STREAM_DATA_GEN -- requirements
Module: stream_data_gen

---
 rtl/stream_gen_pkg.sv | 15 +
 rtl/stream_lfsr.sv | 19 +
 rtl/stream_data_gen.sv | 85 ++++++++
 tb/tb_stream_data_gen.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_gen_pkg.sv
// stream_gen_pkg: pattern modes, FSM states and the Fibonacci LFSR tap table
package stream_gen_pkg;
  typedef enum logic [1:0] {MODE_CNT, MODE_LFSR, MODE_CONST, MODE_WALK} mode_t;
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;
  function automatic logic [63:0] lfsr_taps(input int w);
    return w == 8  ? 64'h0000_0000_0000_00B8 :
           w == 16 ? 64'h0000_0000_0000_D008 :
           w == 32 ? 64'h0000_0000_8020_0003 : 64'hD800_0000_0000_0000;
  endfunction
  function automatic logic [63:0] lfsr_next(input logic [63:0] q, input int w);
    logic [63:0] msk;
    msk = w == 64 ? '1 : (64'd1 << w) - 64'd1;
    return ((q << 1) | {63'd0, ^(q & lfsr_taps(w))}) & msk;
  endfunction
endpackage

// File: rtl/stream_lfsr.sv
// stream_lfsr: DATA_W-bit maximal-length Fibonacci LFSR with load and advance
module stream_lfsr
  import stream_gen_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_async_n,
  input  logic              load,
  input  logic              adv,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] q
);
  // load the seed (zero would lock the register up), otherwise step on advance
  always_ff @(posedge clk or negedge rst_async_n)
    if (!rst_async_n) q <= '0;
    else if (load) q <= seed == '0 ? DATA_W'(1) : seed;
    else if (adv) q <= DATA_W'(lfsr_next(64'(q), DATA_W));
endmodule

// File: rtl/stream_data_gen.sv
// stream_data_gen: ap_ctrl_hs stream pattern generator (counter/LFSR/constant/walking-one)
module stream_data_gen
  import stream_gen_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter int          NUM_WORDS  = 1024,
  parameter logic [63:0] SEED       = 64'd1,
  parameter int          GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_async_n,
  input  logic              ap_start,
  input  logic [1:0]        mode,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  output logic [DATA_W-1:0] Output_1_V_V,
  output logic              Output_1_V_V_ap_vld,
  input  logic              Output_1_V_V_ap_ack,
  output logic [23:0]       word_cnt
);
  localparam logic [23:0]       LAST     = 24'(NUM_WORDS - 1);
  localparam logic [7:0]        GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [DATA_W-1:0] SEED_W   = DATA_W'(SEED);
  if (DATA_W != 8 && DATA_W != 16 && DATA_W != 32 && DATA_W != 64) begin : g_bad_width
    $error("stream_data_gen: DATA_W must be 8, 16, 32 or 64");
  end
  state_t            state, state_nx;
  mode_t             mode_q;
  logic [1:0]        rst_sync;
  logic [DATA_W-1:0] pat, lfsr_q;
  logic [7:0]        gap_cnt;
  logic              start_ok, xfer;
  assign start_ok = state == S_IDLE && ap_start && rst_sync[1];
  assign xfer     = state == S_SEND && Output_1_V_V_ap_ack;
  // two-flop release so no start is taken while reset is still settling
  always_ff @(posedge clk or negedge rst_async_n)
    if (!rst_async_n) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  // state register
  always_ff @(posedge clk or negedge rst_async_n)
    if (!rst_async_n) state <= S_IDLE;
    else state <= state_nx;
  // next-state: a transfer ends the run, opens a gap, or goes straight to the next word
  always_comb
    state_nx = state == S_IDLE ? (start_ok ? S_SEND : S_IDLE) :
               state == S_SEND ? (!xfer ? S_SEND : word_cnt == LAST ? S_DONE :
                                  GAP_CYCLES > 0 ? S_GAP : S_SEND) :
               state == S_GAP  ? (gap_cnt == GAP_LAST ? S_SEND : S_GAP) : S_IDLE;
  // outputs decoded from state; data comes from the LFSR only in LFSR mode
  always_comb begin
    ap_idle             = state == S_IDLE;
    ap_done             = state == S_DONE;
    ap_ready            = start_ok;
    Output_1_V_V_ap_vld = state == S_SEND;
    Output_1_V_V        = mode_q == MODE_LFSR ? lfsr_q : pat;
  end
  // run datapath: mode latch, word count, gap timer and the inline patterns
  always_ff @(posedge clk or negedge rst_async_n)
    if (!rst_async_n) begin
      mode_q   <= MODE_CNT;
      word_cnt <= '0;
      pat      <= '0;
      gap_cnt  <= '0;
    end else begin
      gap_cnt <= state == S_GAP ? gap_cnt + 8'd1 : 8'd0;
      if (start_ok) begin
        mode_q   <= mode_t'(mode);
        word_cnt <= '0;
        pat      <= mode == MODE_WALK ? DATA_W'(1) : SEED_W;
      end else if (xfer) begin
        word_cnt <= word_cnt + 24'd1;
        pat      <= mode_q == MODE_CNT  ? pat + DATA_W'(1) :
                    mode_q == MODE_WALK ? {pat[DATA_W-2:0], pat[DATA_W-1]} : pat;
      end
    end
  stream_lfsr #(.DATA_W(DATA_W)) u_lfsr (
    .clk         (clk),
    .rst_async_n (rst_async_n),
    .load        (start_ok),
    .adv         (xfer),
    .seed        (SEED_W),
    .q           (lfsr_q)
  );
endmodule

// File: tb/tb_stream_data_gen.sv
// tb_stream_data_gen: four parameterisations checked against a behavioural pattern model
module tb_stream_data_gen;
  int checks = 0, errors = 0;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst_n;
  logic [3:0] start, ack, done, idle, ready, vld;
  logic [1:0] mode [4];
  logic [63:0] dat [4];
  logic [23:0] cnt [4];
  logic [31:0] d0, d1;
  logic [7:0] d2;
  logic [15:0] d3;
  assign dat[0] = 64'(d0);
  assign dat[1] = 64'(d1);
  assign dat[2] = 64'(d2);
  assign dat[3] = 64'(d3);
  localparam int W [4] = '{32, 32, 8, 16};
  localparam logic [63:0] SD [4] = '{64'd0, 64'hFFFF_FFFE, 64'd0, 64'd1};
  localparam int GP [4] = '{0, 3, 0, 0};

  stream_data_gen #(.DATA_W(32), .NUM_WORDS(4), .SEED(64'd0), .GAP_CYCLES(0)) u0 (
    .clk(clk), .rst_async_n(rst_n), .ap_start(start[0]), .mode(mode[0]), .ap_done(done[0]),
    .ap_idle(idle[0]), .ap_ready(ready[0]), .Output_1_V_V(d0), .Output_1_V_V_ap_vld(vld[0]),
    .Output_1_V_V_ap_ack(ack[0]), .word_cnt(cnt[0]));
  stream_data_gen #(.DATA_W(32), .NUM_WORDS(10), .SEED(64'hFFFF_FFFE), .GAP_CYCLES(3)) u1 (
    .clk(clk), .rst_async_n(rst_n), .ap_start(start[1]), .mode(mode[1]), .ap_done(done[1]),
    .ap_idle(idle[1]), .ap_ready(ready[1]), .Output_1_V_V(d1), .Output_1_V_V_ap_vld(vld[1]),
    .Output_1_V_V_ap_ack(ack[1]), .word_cnt(cnt[1]));
  stream_data_gen #(.DATA_W(8), .NUM_WORDS(256), .SEED(64'd0), .GAP_CYCLES(0)) u2 (
    .clk(clk), .rst_async_n(rst_n), .ap_start(start[2]), .mode(mode[2]), .ap_done(done[2]),
    .ap_idle(idle[2]), .ap_ready(ready[2]), .Output_1_V_V(d2), .Output_1_V_V_ap_vld(vld[2]),
    .Output_1_V_V_ap_ack(ack[2]), .word_cnt(cnt[2]));
  stream_data_gen #(.DATA_W(16), .NUM_WORDS(18), .SEED(64'd1), .GAP_CYCLES(0)) u3 (
    .clk(clk), .rst_async_n(rst_n), .ap_start(start[3]), .mode(mode[3]), .ap_done(done[3]),
    .ap_idle(idle[3]), .ap_ready(ready[3]), .Output_1_V_V(d3), .Output_1_V_V_ap_vld(vld[3]),
    .Output_1_V_V_ap_ack(ack[3]), .word_cnt(cnt[3]));

  function automatic logic [63:0] msk(input int i);
    return W[i] == 64 ? '1 : (64'd1 << W[i]) - 64'd1;
  endfunction

  // expected word k for counter (0), constant (2) and walking-one (3) modes
  function automatic logic [63:0] model(input int i, input int m, input int k);
    return m == 0 ? (SD[i] + 64'(k)) & msk(i) : m == 2 ? SD[i] & msk(i) : 64'd1 << (k % W[i]);
  endfunction

  task automatic start_run(input int i, input logic [1:0] m, output logic rdy, output logic idl);
    mode[i] = m;
    start[i] = 1'b1;
    #1;
    rdy = ready[i];
    idl = idle[i];
    @(posedge clk); #1;
    start[i] = 1'b0;
  endtask

  // collect accepted words; ackp 0=always, 1=1 on/2 off, 2=random
  task automatic capture(input int i, input int ackp, input int stop_n, input bit disturb,
                         output logic [63:0] q[$], output int e_stab, output int e_gap,
                         output int e_done, output bit tmo);
    bit hold = 0, fin = 0;
    logic [63:0] pd = 0;
    int low = 0, last = -10, c = 0;
    q.delete(); e_stab = 0; e_gap = 0; e_done = 0;
    while (!fin && c < 3000) begin
      ack[i] = ackp == 0 ? 1'b1 : ackp == 1 ? 1'(c % 3 == 0) : 1'($urandom_range(0, 1));
      if (disturb) begin
        start[i] = 1'(c == 2 || c == 5);
        if (c == 2) mode[i] = ~mode[i];
      end
      #1;
      if (hold && (!vld[i] || dat[i] !== pd)) e_stab++;
      if (ready[i]) e_done++;
      if (done[i]) begin
        if (last != c - 1) e_done++;
        fin = 1;
      end else if (vld[i] && ack[i]) begin
        q.push_back(dat[i]);
        if (q.size() > 1 && low != GP[i]) e_gap++;
        low = 0;
        last = c;
        if (stop_n != 0 && q.size() == stop_n) fin = 1;
      end else if (!vld[i]) low++;
      hold = vld[i] && !ack[i];
      pd = dat[i];
      @(posedge clk); #1;
      c++;
    end
    tmo = !fin;
    if (fin && stop_n == 0 && (done[i] !== 1'b0 || idle[i] !== 1'b1)) e_done++;
    ack[i] = 1'b0;
    start[i] = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start[0] = 1'b1;
    #3;
    checks++;
    if ({idle, done, ready, vld} !== 16'hF000) begin
      errors++;
      $display("FAIL reset_ctrl: idle/done/ready/vld=%h want F000", {idle, done, ready, vld});
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dat[i] !== 64'd0 || cnt[i] !== 24'd0) begin
        errors++;
        $display("FAIL reset_data[%0d]: data=%h cnt=%0d want 0 0", i, dat[i], cnt[i]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (idle[0] !== 1'b1 || vld[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: idle=%b vld=%b want 1 0 after first edge", idle[0], vld[0]);
    end
    start[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_counter_basic;
    logic [63:0] q[$];
    int es, eg, ed;
    bit tmo;
    logic rdy, idl;
    start_run(0, 2'd0, rdy, idl);
    checks++;
    if (rdy !== 1'b1 || idl !== 1'b1) begin
      errors++;
      $display("FAIL start_handshake: ready=%b idle=%b want 1 1", rdy, idl);
    end
    capture(0, 0, 0, 0, q, es, eg, ed, tmo);
    checks++;
    if (tmo || q.size() != 4) begin
      errors++;
      $display("FAIL cnt_basic_len: words=%0d timeout=%0d want 4 0", q.size(), tmo);
    end
    foreach (q[k]) begin
      checks++;
      if (q[k] !== model(0, 0, k)) begin
        errors++;
        $display("FAIL cnt_basic_word[%0d]: got %h want %h", k, q[k], model(0, 0, k));
      end
    end
    checks++;
    if (eg != 0 || ed != 0 || cnt[0] !== 24'd4) begin
      errors++;
      $display("FAIL cnt_basic_timing: gap_err=%0d done_err=%0d word_cnt=%0d want 0 0 4", eg, ed, cnt[0]);
    end
  endtask

  task automatic test_wrap_gap;
    logic [63:0] q[$];
    int es, eg, ed;
    bit tmo;
    logic rdy, idl;
    start_run(1, 2'd0, rdy, idl);
    capture(1, 1, 0, 0, q, es, eg, ed, tmo);
    checks++;
    if (tmo || q.size() != 10) begin
      errors++;
      $display("FAIL wrap_len: words=%0d timeout=%0d want 10 0", q.size(), tmo);
    end
    foreach (q[k]) begin
      checks++;
      if (q[k] !== model(1, 0, k)) begin
        errors++;
        $display("FAIL wrap_word[%0d]: got %h want %h", k, q[k], model(1, 0, k));
      end
    end
    checks++;
    if (es != 0 || eg != 0 || ed != 0 || cnt[1] !== 24'd10) begin
      errors++;
      $display("FAIL gap_handshake: stable_err=%0d gap_err=%0d done_err=%0d cnt=%0d want 0 0 0 10",
               es, eg, ed, cnt[1]);
    end
  endtask

  task automatic test_constant;
    logic [63:0] q[$];
    int es, eg, ed;
    bit tmo;
    logic rdy, idl;
    start_run(1, 2'd2, rdy, idl);
    capture(1, 2, 0, 1, q, es, eg, ed, tmo);
    checks++;
    if (tmo || q.size() != 10 || ed != 0) begin
      errors++;
      $display("FAIL const_ignore_start: words=%0d done_err=%0d timeout=%0d want 10 0 0", q.size(), ed, tmo);
    end
    foreach (q[k]) begin
      checks++;
      if (q[k] !== model(1, 2, k)) begin
        errors++;
        $display("FAIL const_word[%0d]: got %h want %h", k, q[k], model(1, 2, k));
      end
    end
  endtask

  task automatic test_walking;
    logic [63:0] q[$];
    int es, eg, ed;
    bit tmo;
    logic rdy, idl;
    start_run(3, 2'd3, rdy, idl);
    capture(3, 2, 0, 0, q, es, eg, ed, tmo);
    checks++;
    if (tmo || q.size() != 18 || es != 0 || ed != 0) begin
      errors++;
      $display("FAIL walk_run: words=%0d stable_err=%0d done_err=%0d want 18 0 0", q.size(), es, ed);
    end
    foreach (q[k]) begin
      checks++;
      if (q[k] !== model(3, 3, k)) begin
        errors++;
        $display("FAIL walk_word[%0d]: got %h want %h", k, q[k], model(3, 3, k));
      end
    end
  endtask

  task automatic test_lfsr8;
    logic [63:0] q[$];
    int es, eg, ed, bad;
    bit tmo;
    logic rdy, idl;
    bit seen [logic [63:0]];
    start_run(2, 2'd1, rdy, idl);
    capture(2, 0, 0, 0, q, es, eg, ed, tmo);
    checks++;
    if (tmo || q.size() != 256) begin
      errors++;
      $display("FAIL lfsr8_len: words=%0d want 256", q.size());
    end else begin
      bad = 0;
      for (int k = 0; k < 255; k++) begin
        if (q[k] == 64'd0 || seen.exists(q[k])) bad++;
        seen[q[k]] = 1;
        if (k > 0 && (q[k] >> 1) !== (q[k-1] & (msk(2) >> 1))) bad++;
      end
      checks++;
      if (q[0] !== 64'h01 || q[255] !== 64'h01) begin
        errors++;
        $display("FAIL lfsr8_ends: first=%h word255=%h want 01 01", q[0], q[255]);
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL lfsr8_sequence: %0d zero/duplicate/non-shift words want 0", bad);
      end
    end
  endtask

  task automatic test_random;
    logic [63:0] q[$];
    int es, eg, ed, m;
    bit tmo;
    logic rdy, idl;
    for (int r = 0; r < 6; r++) begin
      m = $urandom_range(0, 3);
      start_run(1, 2'(m), rdy, idl);
      capture(1, 2, 0, 0, q, es, eg, ed, tmo);
      checks++;
      if (tmo || q.size() != 10 || es != 0 || eg != 0 || ed != 0) begin
        errors++;
        $display("FAIL rand_run%0d mode %0d: words=%0d stab=%0d gap=%0d done=%0d want 10 0 0 0",
                 r, m, q.size(), es, eg, ed);
      end
      foreach (q[k]) begin
        checks++;
        if (m == 1 ? (k == 0 ? q[k] !== SD[1] : (q[k] >> 1) !== (q[k-1] & (msk(1) >> 1)))
                   : q[k] !== model(1, m, k)) begin
          errors++;
          $display("FAIL rand_word run%0d mode %0d [%0d]: got %h", r, m, k, q[k]);
        end
      end
    end
  endtask

  task automatic test_reset_midrun;
    logic [63:0] q[$];
    int es, eg, ed;
    bit tmo;
    logic rdy, idl;
    start_run(1, 2'd0, rdy, idl);
    capture(1, 0, 5, 0, q, es, eg, ed, tmo);
    checks++;
    if (tmo || cnt[1] !== 24'd5) begin
      errors++;
      $display("FAIL midrun_count: word_cnt=%0d want 5", cnt[1]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({idle[1], done[1], ready[1], vld[1]} !== 4'b1000 || dat[1] !== 64'd0 || cnt[1] !== 24'd0) begin
      errors++;
      $display("FAIL midrun_reset: idle/done/ready/vld=%b data=%h cnt=%0d want 1000 0 0",
               {idle[1], done[1], ready[1], vld[1]}, dat[1], cnt[1]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start_run(1, 2'd0, rdy, idl);
    capture(1, 0, 0, 0, q, es, eg, ed, tmo);
    checks++;
    if (tmo || q.size() != 10 || q[0] !== SD[1]) begin
      errors++;
      $display("FAIL restart: words=%0d first=%h want 10 %h", q.size(), q.size() ? q[0] : 64'd0, SD[1]);
    end
    foreach (q[k]) begin
      checks++;
      if (q[k] !== model(1, 0, k)) begin
        errors++;
        $display("FAIL restart_word[%0d]: got %h want %h", k, q[k], model(1, 0, k));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = '0;
    ack = '0;
    for (int i = 0; i < 4; i++) mode[i] = 2'd0;
    test_reset;
    test_counter_basic;
    test_wrap_gap;
    test_constant;
    test_walking;
    test_lfsr8;
    test_random;
    test_reset_midrun;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
